// File: rtl/frame_deserializer.sv
// Streams raster-order pixels into a double-buffered N x N frame store.
// A completed frame is presented on image_out until the consumer acknowledges it.
module frame_deserializer #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 pix_in,
  input  logic                         pix_valid,
  input  logic                         pix_sof,
  output logic                         pix_ready,
  output logic [N-1:0][N-1:0][W-1:0]   image_out,
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic                         frame_err
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] Last = CW'(N - 1);

  typedef logic [N-1:0][N-1:0][W-1:0] frame_t;
  typedef enum logic {StFill, StHold} state_e;

  state_e          state_q;
  logic [CW-1:0]   row_q, col_q;
  frame_t          wr_q, rd_q;
  logic            valid_q, err_q, ready_q;

  logic            accept, restart, last_px;
  logic [CW-1:0]   row_eff, col_eff;
  frame_t          wr_d;

  always_comb begin
    accept  = pix_valid & ready_q;
    // A start-of-frame marker mid-frame drops the partial frame and restarts at (0,0).
    restart = accept & pix_sof & ((row_q != '0) | (col_q != '0));
    row_eff = restart ? '0 : row_q;
    col_eff = restart ? '0 : col_q;
    last_px = accept & (row_eff == Last) & (col_eff == Last);
    wr_d    = wr_q;
    if (accept) begin
      wr_d[row_eff][col_eff] = pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      row_q   <= '0;
      col_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      err_q <= restart;
      wr_q  <= wr_d;
      unique case (state_q)
        StFill: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (last_px) begin
              row_q <= '0;
              col_q <= '0;
            end else if (col_eff == Last) begin
              row_q <= row_eff + CW'(1);
              col_q <= '0;
            end else begin
              row_q <= row_eff;
              col_q <= col_eff + CW'(1);
            end
          end
          if (last_px) begin
            // An ack arriving with the last pixel frees the read bank in time for the swap.
            if (!valid_q || frame_ack) begin
              rd_q    <= wr_d;
              valid_q <= 1'b1;
            end else begin
              state_q <= StHold;
              ready_q <= 1'b0;
            end
          end else if (valid_q && frame_ack) begin
            valid_q <= 1'b0;
          end
        end
        StHold: begin
          ready_q <= 1'b0;
          if (frame_ack) begin
            rd_q    <= wr_q;
            state_q <= StFill;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign pix_ready   = ready_q;
  assign image_out   = rd_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer: the driver models accepted pixels as frames,
// a monitor pops expected frames whenever a new frame is presented.
module tb_frame_deserializer;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NP = N * N;

  typedef logic [N-1:0][N-1:0][W-1:0] frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_sof = 1'b0;
  logic         frame_ack = 1'b0;
  logic         pix_ready;
  logic         frame_valid;
  logic         frame_err;
  frame_t       image_out;

  int     checks = 0;
  int     failures = 0;
  frame_t exp_q[$];
  int     cur[$];
  int     err_pending = 0;
  bit     auto_ack = 1'b0;
  int     gap_pct = 0;

  always #5 clk = ~clk;

  frame_deserializer #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .image_out  (image_out),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t to_frame(input int q[$]);
    frame_t f;
    f = '0;
    for (int i = 0; i < q.size(); i++) f[i / N][i % N] = W'(q[i]);
    return f;
  endfunction

  // Reference model: a frame is simply the next NP accepted pixels; an SOF mid-frame restarts it.
  task automatic model_accept(input int val, input bit sof);
    if (sof && cur.size() != 0) begin
      err_pending++;
      cur.delete();
    end
    cur.push_back(val & 255);
    if (cur.size() == NP) begin
      exp_q.push_back(to_frame(cur));
      cur.delete();
    end
  endtask

  task automatic send_pixel(input int val, input bit sof, input bit ack);
    bit ok;
    bit r;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      if (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
        pix_valid = 1'b0;
        r = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_in    = W'(val);
        pix_sof   = sof;
        r         = pix_ready;
      end
      if (ack) frame_ack = 1'b1;
      @(posedge clk);
      if (pix_valid && r) begin
        ok = 1'b1;
        model_accept(val, sof);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      if (ack) frame_ack = 1'b0;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_pixel: pixel %0d not accepted within 1000 cycles, expected acceptance", val);
    end
  endtask

  task automatic send_frame(input int base, input bit sof_first);
    for (int i = 0; i < NP; i++) send_pixel(base + i, sof_first && i == 0, 1'b0);
  endtask

  task automatic ack_once();
    frame_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    cur.delete();
    exp_q.delete();
    err_pending = 0;
    repeat (2) @(negedge clk);
    chk({tag, "_valid"}, int'(frame_valid), 0);
    chk({tag, "_err"}, int'(frame_err), 0);
    chk({tag, "_ready"}, int'(pix_ready), 0);
    chk({tag, "_image_zero"}, int'(image_out == '0), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_ready_after"}, int'(pix_ready), 1);
  endtask

  // Monitor: every newly presented frame must match the oldest expected frame.
  initial begin
    frame_t prev_img;
    frame_t e;
    bit     prev_valid;
    prev_valid = 1'b0;
    prev_img   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (frame_err) begin
        checks++;
        if (err_pending == 0) begin
          failures++;
          $display("FAIL frame_err: got 1 expected 0 (no resync pending)");
        end else begin
          err_pending--;
        end
      end
      if (frame_valid && (!prev_valid || image_out != prev_img)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_presented: got frame %h expected none", image_out);
        end else begin
          e = exp_q.pop_front();
          if (image_out !== e) begin
            failures++;
            $display("FAIL frame_data: got %h expected %h", image_out, e);
          end
        end
      end
      prev_valid = frame_valid;
      prev_img   = image_out;
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_ack) frame_ack = ($urandom_range(3) == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d[$];
    do_reset("reset");

    // Basic frame and latency
    send_frame(0, 1'b1);
    chk("latency_valid", int'(frame_valid), 1);
    chk("a_00", int'(image_out[0][0]), 0);
    chk("a_10", int'(image_out[1][0]), 5);
    chk("a_34", int'(image_out[3][4]), 19);
    chk("a_44", int'(image_out[4][4]), 24);

    // Second frame with no ack stalls in HOLD
    send_frame(100, 1'b1);
    chk("hold_ready", int'(pix_ready), 0);
    chk("hold_img00", int'(image_out[0][0]), 0);
    ack_once();
    chk("hold_ack_img00", int'(image_out[0][0]), 100);
    chk("hold_ack_valid", int'(frame_valid), 1);
    chk("hold_ack_ready", int'(pix_ready), 1);

    // Ack coincident with the last pixel avoids HOLD
    for (int i = 0; i < NP; i++) send_pixel(150 + i, i == 0, i == NP - 1);
    chk("swap_ready", int'(pix_ready), 1);
    chk("swap_valid", int'(frame_valid), 1);
    chk("swap_img44", int'(image_out[4][4]), 174);
    ack_once();
    chk("ack_clears_valid", int'(frame_valid), 0);

    // Resync via SOF mid-frame
    for (int i = 0; i < 10; i++) send_pixel(i, i == 0, 1'b0);
    send_pixel(200, 1'b1, 1'b0);
    chk("err_pulse", int'(frame_err), 1);
    send_pixel(201, 1'b0, 1'b0);
    chk("err_one_cycle", int'(frame_err), 0);
    for (int i = 2; i < NP; i++) send_pixel(200 + i, 1'b0, 1'b0);
    chk("resync_valid", int'(frame_valid), 1);
    chk("resync_img00", int'(image_out[0][0]), 200);
    ack_once();

    // Reset mid-frame discards the partial frame; SOF is optional
    for (int i = 0; i < 12; i++) send_pixel(i, i == 0, 1'b0);
    do_reset("midreset");
    send_frame(50, 1'b0);
    chk("post_reset_valid", int'(frame_valid), 1);
    chk("post_reset_img00", int'(image_out[0][0]), 50);
    chk("post_reset_img44", int'(image_out[4][4]), 74);
    ack_once();

    // Same data with and without valid gaps
    for (int i = 0; i < NP; i++) d.push_back($urandom_range(255));
    for (int i = 0; i < NP; i++) send_pixel(d[i], i == 0, 1'b0);
    chk("nogap_image", int'(image_out == to_frame(d)), 1);
    ack_once();
    gap_pct = 40;
    for (int i = 0; i < NP; i++) send_pixel(d[i], i == 0, 1'b0);
    chk("gap_image", int'(image_out == to_frame(d)), 1);
    ack_once();

    // Random traffic with random acks and occasional resync
    gap_pct  = 30;
    auto_ack = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NP; i++) begin
        send_pixel($urandom_range(255),
                   (i == 0) ? bit'($urandom_range(1)) : ($urandom_range(39) == 0), 1'b0);
      end
    end
    repeat (100) @(negedge clk);
    auto_ack = 1'b0;
    @(negedge clk);
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("errs_outstanding", err_pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
